multicycle_control: RTL and testbench

- Multicycle sequencing controller for the custom 32-bit ISA (lw, sw, add, nor, nori, not, rolv, rorv, bleu, jr, jal).
- Replaces single-cycle decode so one shared memory port and one ALU are reused across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps.
- Drives the datapath muxes, write enables and ALU code every cycle.
- Stalls on a memory ready handshake.

---
 rtl/multicycle_control.sv | 272 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Sequencing controller for a multicycle implementation of the custom 32-bit
// ISA (lw, sw, add, nor, nori, not, rolv, rorv, bleu, jr, jal). One memory port
// and one ALU are shared across the FETCH / DECODE / EXECUTE / MEM / WRITEBACK
// steps. This block steps through those phases and drives every datapath
// select, write enable and ALU code on every cycle.
//
// Outputs are a Moore-style decode of the current state, qualified by the
// opcode (ALU code, writeback destination), alu_leu (branch taken) and
// mem_ready (completion of a memory step). While reset is high every output
// is forced to 0.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   opcode[5:0]  instruction register bits [31:26]
//   mem_ready    memory finished the current read or write this cycle
//   alu_leu      ALU unsigned less-or-equal flag (used by bleu)
//   mem_read     memory read request
//   mem_write    memory write request
//   iord         address select: 0 = PC, 1 = ALUOut
//   ir_write     instruction register load
//   pc_write     PC load
//   pc_src[1:0]  00 = ALU result, 01 = ALUOut, 10 = reg A, 11 = jump target
//   reg_write    register file write enable
//   reg_dst[1:0] 00 = rt, 01 = rd, 10 = r31
//   mem_to_reg   00 = ALUOut, 01 = MDR, 10 = PC
//   alu_src_a    0 = PC, 1 = reg A
//   alu_src_b    00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = imm << 2
//   alu_control  ALU operation code
//   instr_done   one-cycle pulse on the last cycle of each instruction
//   illegal      high while halted (unknown opcode or memory timeout)
//   mem_timeout  sticky: a memory step waited too long for mem_ready
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_leu,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [4:0] alu_control,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    ADDR   = 4'd2,
    MEM_RD = 4'd3,
    LW_WB  = 4'd4,
    MEM_WR = 4'd5,
    EXEC_R = 4'd6,
    EXEC_I = 4'd7,
    ALU_WB = 4'd8,
    BRANCH = 4'd9,
    JR     = 4'd10,
    JAL    = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [4:0] ALU_ADD  = 5'b10000;
  localparam logic [4:0] ALU_BLEU = 5'b01000;

  // The counter holds the number of not-ready cycles already seen, so the
  // MEM_WAIT_MAX-th consecutive not-ready cycle is the one where it equals
  // MEM_WAIT_MAX-1. That keeps the count within 4 bits for the default of 15.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_next;
  logic       timeout_q;
  logic       waiting;
  logic       wait_expired;

  // First execution state for the opcode held in the instruction register.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t t;
    case (op)
      OP_LW, OP_SW:                             t = ADDR;
      OP_ADD, OP_NOR, OP_NOT, OP_ROLV, OP_RORV: t = EXEC_R;
      OP_NORI:                                  t = EXEC_I;
      OP_BLEU:                                  t = BRANCH;
      OP_JR:                                    t = JR;
      OP_JAL:                                   t = JAL;
      default:                                  t = HALT;
    endcase
    return t;
  endfunction

  // States that own the memory port and may stall on mem_ready.
  assign waiting      = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign wait_expired = waiting && !mem_ready && (wait_cnt == WAIT_LAST);

  // Counter restarts whenever the stall ends, either by completion or by
  // giving up and halting.
  assign wait_cnt_next = (waiting && !mem_ready && !wait_expired) ? wait_cnt + 4'd1 : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (wait_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (mem_ready)         state_next = DECODE;
        else if (wait_expired) state_next = HALT;
      end
      DECODE: state_next = decode_target(opcode);
      ADDR:   state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready)         state_next = LW_WB;
        else if (wait_expired) state_next = HALT;
      end
      LW_WB:  state_next = FETCH;
      MEM_WR: begin
        if (mem_ready)         state_next = FETCH;
        else if (wait_expired) state_next = HALT;
      end
      EXEC_R: state_next = ALU_WB;
      EXEC_I: state_next = ALU_WB;
      ALU_WB: state_next = FETCH;
      BRANCH: state_next = FETCH;
      JR:     state_next = FETCH;
      JAL:    state_next = FETCH;
      HALT:   state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 5'b00000;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;

    if (!reset) begin
      mem_timeout = timeout_q;
      case (state)
        FETCH: begin
          // ALU computes PC+4 while the instruction is read; both land on
          // the edge where memory reports ready.
          mem_read    = 1'b1;
          alu_src_b   = 2'b01;
          alu_control = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        DECODE: begin
          // Speculative branch target (PC+4 + imm<<2) into ALUOut.
          alu_src_b   = 2'b11;
          alu_control = ALU_ADD;
        end
        ADDR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        LW_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        EXEC_R: begin
          alu_src_a   = 1'b1;
          alu_control = opcode[5:1];
        end
        EXEC_I: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = opcode[5:1];
        end
        ALU_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (opcode == OP_NORI) ? 2'b00 : 2'b01;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_BLEU;
          pc_src      = 2'b01;
          pc_write    = alu_leu;
          instr_done  = 1'b1;
        end
        JR: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        JAL: begin
          // r31 receives the current PC (already PC+4) on the same edge the
          // PC takes the jump target.
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          pc_write   = 1'b1;
          pc_src     = 2'b11;
          instr_done = 1'b1;
        end
        HALT: begin
          illegal = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench. Each instruction is expanded into its list of steps
// (fetch / decode / execute / memory / writeback) with the output pattern that
// step must show; the playback task drives inputs one cycle at a time and
// compares every output against that list. A few literal expectations per
// test pin down instruction length and key control bits.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       alu_leu;
  logic       mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [4:0] alu_control;
  logic       instr_done, illegal, mem_timeout;

  multicycle_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .alu_leu(alu_leu), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .instr_done(instr_done), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_control;
    logic       instr_done;
    logic       illegal;
    logic       mem_timeout;
  } ovec_t;

  typedef struct {
    string      tag;
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic       leu;
    ovec_t      exp;
  } cyc_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ADD = 6'b100000;
  localparam logic [5:0] NOR = 6'b100110, NOT = 6'b000100, ROLV = 6'b000000;
  localparam logic [5:0] RORV = 6'b000010, NORI = 6'b001110, BLEU = 6'b010000;
  localparam logic [5:0] JR = 6'b001000, JAL = 6'b000011, BAD = 6'b111111;

  cyc_t       plan[$];
  ovec_t      obs[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc_cnt = 0;
  int         last_len = 0;
  logic       model_to = 1'b0;
  logic [5:0] cur_op = 6'b0;

  // ---------------- step patterns ----------------
  function automatic ovec_t s_fetch(input logic rdy);
    ovec_t v = '0;
    v.mem_read = 1; v.alu_src_b = 2'b01; v.alu_control = 5'b10000;
    v.ir_write = rdy; v.pc_write = rdy;
    return v;
  endfunction
  function automatic ovec_t s_decode();
    ovec_t v = '0;
    v.alu_src_b = 2'b11; v.alu_control = 5'b10000;
    return v;
  endfunction
  function automatic ovec_t s_addr();
    ovec_t v = '0;
    v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_control = 5'b10000;
    return v;
  endfunction
  function automatic ovec_t s_memrd();
    ovec_t v = '0;
    v.mem_read = 1; v.iord = 1;
    return v;
  endfunction
  function automatic ovec_t s_lwwb();
    ovec_t v = '0;
    v.reg_write = 1; v.mem_to_reg = 2'b01; v.instr_done = 1;
    return v;
  endfunction
  function automatic ovec_t s_memwr(input logic rdy);
    ovec_t v = '0;
    v.mem_write = 1; v.iord = 1; v.instr_done = rdy;
    return v;
  endfunction
  function automatic ovec_t s_exec(input logic [5:0] op, input logic imm);
    ovec_t v = '0;
    v.alu_src_a = 1; v.alu_src_b = imm ? 2'b10 : 2'b00; v.alu_control = op[5:1];
    return v;
  endfunction
  function automatic ovec_t s_aluwb(input logic imm);
    ovec_t v = '0;
    v.reg_write = 1; v.reg_dst = imm ? 2'b00 : 2'b01; v.instr_done = 1;
    return v;
  endfunction
  function automatic ovec_t s_branch(input logic leu);
    ovec_t v = '0;
    v.alu_src_a = 1; v.alu_control = 5'b01000; v.pc_src = 2'b01;
    v.pc_write = leu; v.instr_done = 1;
    return v;
  endfunction
  function automatic ovec_t s_jr();
    ovec_t v = '0;
    v.pc_write = 1; v.pc_src = 2'b10; v.instr_done = 1;
    return v;
  endfunction
  function automatic ovec_t s_jal();
    ovec_t v = '0;
    v.reg_write = 1; v.reg_dst = 2'b10; v.mem_to_reg = 2'b10;
    v.pc_write = 1; v.pc_src = 2'b11; v.instr_done = 1;
    return v;
  endfunction
  function automatic ovec_t s_halt();
    ovec_t v = '0;
    v.illegal = 1;
    return v;
  endfunction

  // ---------------- planning ----------------
  task automatic push(input string tag, input logic rdy, input logic leu, input ovec_t e);
    cyc_t c;
    c.tag = tag; c.rst = 1'b0; c.op = cur_op; c.rdy = rdy; c.leu = leu;
    c.exp = e;
    c.exp.mem_timeout = model_to;
    plan.push_back(c);
  endtask

  task automatic push_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c.tag = "reset"; c.rst = 1'b1; c.op = cur_op; c.rdy = 1'b0; c.leu = 1'b0;
      c.exp = '0;
      plan.push_back(c);
    end
    model_to = 1'b0;
  endtask

  // Expand one instruction into its steps.
  task automatic plan_instr(input logic [5:0] op, input int fw, input int mw, input logic leu);
    cur_op = op;
    for (int i = 0; i < fw; i++) push("fetch_wait", 1'b0, leu, s_fetch(1'b0));
    push("fetch", 1'b1, leu, s_fetch(1'b1));
    push("decode", 1'b1, leu, s_decode());
    if (op == LW) begin
      push("addr", 1'b1, leu, s_addr());
      for (int i = 0; i < mw; i++) push("memrd_wait", 1'b0, leu, s_memrd());
      push("memrd", 1'b1, leu, s_memrd());
      push("lw_wb", 1'b1, leu, s_lwwb());
    end else if (op == SW) begin
      push("addr", 1'b1, leu, s_addr());
      for (int i = 0; i < mw; i++) push("memwr_wait", 1'b0, leu, s_memwr(1'b0));
      push("memwr", 1'b1, leu, s_memwr(1'b1));
    end else if (op == ADD || op == NOR || op == NOT || op == ROLV || op == RORV) begin
      push("exec_r", 1'b1, leu, s_exec(op, 1'b0));
      push("alu_wb", 1'b1, leu, s_aluwb(1'b0));
    end else if (op == NORI) begin
      push("exec_i", 1'b1, leu, s_exec(op, 1'b1));
      push("alu_wb_i", 1'b1, leu, s_aluwb(1'b1));
    end else if (op == BLEU) begin
      push("branch", 1'b1, leu, s_branch(leu));
    end else if (op == JR) begin
      push("jr", 1'b1, leu, s_jr());
    end else if (op == JAL) begin
      push("jal", 1'b1, leu, s_jal());
    end
  endtask

  // ---------------- playback and compare ----------------
  task automatic check_vec(input string tag, input ovec_t got, input ovec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_lit(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic play();
    ovec_t got;
    obs.delete();
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset = plan[i].rst; opcode = plan[i].op;
      mem_ready = plan[i].rdy; alu_leu = plan[i].leu;
      #4;
      got.mem_read = mem_read;       got.mem_write = mem_write;
      got.iord = iord;               got.ir_write = ir_write;
      got.pc_write = pc_write;       got.pc_src = pc_src;
      got.reg_write = reg_write;     got.reg_dst = reg_dst;
      got.mem_to_reg = mem_to_reg;   got.alu_src_a = alu_src_a;
      got.alu_src_b = alu_src_b;     got.alu_control = alu_control;
      got.instr_done = instr_done;   got.illegal = illegal;
      got.mem_timeout = mem_timeout;
      check_vec(plan[i].tag, got, plan[i].exp);
      obs.push_back(got);
      if (plan[i].rst) begin
        cyc_cnt = 0;
      end else begin
        cyc_cnt++;
        if (got.instr_done === 1'b1) begin
          last_len = cyc_cnt;
          cyc_cnt = 0;
        end
      end
    end
    plan.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; opcode = 6'b0; mem_ready = 1'b0; alu_leu = 1'b0;

    push_reset(2);
    play();

    // add, no waits: 4 cycles, rd writeback
    plan_instr(ADD, 0, 0, 1'b0);
    play();
    chk_lit("add_len", last_len, 4);
    chk_lit("add_exec_aluctl", int'(obs[2].alu_control), 16);
    chk_lit("add_wb_regdst", int'(obs[3].reg_dst), 1);
    chk_lit("add_wb_regwrite", int'(obs[3].reg_write), 1);
    chk_lit("add_done_early", int'(obs[2].instr_done), 0);

    // lw: 2 fetch waits + 1 read wait = 8 cycles
    plan_instr(LW, 2, 1, 1'b0);
    play();
    chk_lit("lw_len", last_len, 8);
    chk_lit("lw_irw_wait", int'(obs[1].ir_write), 0);
    chk_lit("lw_irw_ready", int'(obs[2].ir_write), 1);
    chk_lit("lw_wb_m2r", int'(obs[7].mem_to_reg), 1);
    chk_lit("lw_wb_regdst", int'(obs[7].reg_dst), 0);

    // bleu taken, then not taken
    plan_instr(BLEU, 0, 0, 1'b1);
    play();
    chk_lit("bleu_t_len", last_len, 3);
    chk_lit("bleu_t_pcw", int'(obs[2].pc_write), 1);
    chk_lit("bleu_t_pcsrc", int'(obs[2].pc_src), 1);
    plan_instr(BLEU, 0, 0, 1'b0);
    play();
    chk_lit("bleu_nt_len", last_len, 3);
    chk_lit("bleu_nt_pcw", int'(obs[2].pc_write), 0);

    // jal: link and jump on the same cycle
    plan_instr(JAL, 0, 0, 1'b0);
    play();
    chk_lit("jal_len", last_len, 3);
    chk_lit("jal_regw", int'(obs[2].reg_write), 1);
    chk_lit("jal_regdst", int'(obs[2].reg_dst), 2);
    chk_lit("jal_m2r", int'(obs[2].mem_to_reg), 2);
    chk_lit("jal_pcw", int'(obs[2].pc_write), 1);
    chk_lit("jal_pcsrc", int'(obs[2].pc_src), 3);

    // remaining ALU ops, jr and sw with one write wait
    plan_instr(NOR, 0, 0, 1'b0);
    plan_instr(NOT, 0, 0, 1'b1);
    plan_instr(ROLV, 0, 0, 1'b0);
    plan_instr(RORV, 0, 0, 1'b0);
    play();
    plan_instr(NORI, 0, 0, 1'b0);
    play();
    chk_lit("nori_len", last_len, 4);
    chk_lit("nori_aluctl", int'(obs[2].alu_control), 7);
    chk_lit("nori_regdst", int'(obs[3].reg_dst), 0);
    plan_instr(JR, 1, 0, 1'b0);
    play();
    chk_lit("jr_len", last_len, 4);
    plan_instr(SW, 0, 1, 1'b0);
    play();
    chk_lit("sw_len", last_len, 5);

    // unknown opcode: halt for 20 cycles, then reset and resume
    plan_instr(BAD, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) push("halt", 1'b0, i[0], s_halt());
    play();
    chk_lit("halt_illegal_end", int'(obs[21].illegal), 1);
    push_reset(1);
    plan_instr(ADD, 0, 0, 1'b0);
    play();
    chk_lit("post_halt_illegal", int'(obs[1].illegal), 0);
    chk_lit("post_halt_len", last_len, 4);

    // sw stalled, reset in the third write cycle
    cur_op = SW;
    push("fetch", 1'b1, 1'b0, s_fetch(1'b1));
    push("decode", 1'b1, 1'b0, s_decode());
    push("addr", 1'b1, 1'b0, s_addr());
    push("memwr_wait", 1'b0, 1'b0, s_memwr(1'b0));
    push("memwr_wait", 1'b0, 1'b0, s_memwr(1'b0));
    push_reset(1);
    plan_instr(JR, 0, 0, 1'b0);
    play();
    chk_lit("sw_rst_memwrite", int'(obs[5].mem_write), 0);
    chk_lit("sw_rst_fetch_after", int'(obs[6].mem_read), 1);

    // sw stalled 15 cycles: timeout and halt
    cur_op = SW;
    push("fetch", 1'b1, 1'b0, s_fetch(1'b1));
    push("decode", 1'b1, 1'b0, s_decode());
    push("addr", 1'b1, 1'b0, s_addr());
    for (int i = 0; i < 15; i++) push("memwr_stall", 1'b0, 1'b0, s_memwr(1'b0));
    model_to = 1'b1;
    for (int i = 0; i < 3; i++) push("timeout_halt", 1'b0, 1'b0, s_halt());
    play();
    chk_lit("to_flag_before", int'(obs[17].mem_timeout), 0);
    chk_lit("to_flag", int'(obs[18].mem_timeout), 1);
    chk_lit("to_halt_nowrite", int'(obs[18].mem_write), 0);
    push_reset(1);
    plan_instr(ADD, 0, 0, 1'b0);
    play();
    chk_lit("to_cleared", int'(obs[1].mem_timeout), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
